// File: rtl/softmax_pkg.sv
// Shared constants and state encoding for the softmax
// stage sequencers.
package softmax_pkg;

  localparam int SM_ADDR_WIDTH   = 10;
  localparam int SM_TOTAL_VALUES = 5;

  localparam int EXPO_LATENCY  = 8;
  localparam int RECI_LATENCY  = 12;
  localparam int MULTI_LATENCY = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } seq_state_e;

endpackage

// File: rtl/valid_delay_line.sv
// DEPTH-cycle valid shift register; pre_o exposes the value
// that valid_o will take after the next clock edge.
module valid_delay_line #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic valid_i,
  output logic valid_o,
  output logic pre_o
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  generate
    if (DEPTH == 1) begin : g_one
      assign sr_d = valid_i;
    end else begin : g_shift
      assign sr_d = {sr_q[DEPTH-2:0], valid_i};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else if (clr_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign valid_o = sr_q[DEPTH-1];
  assign pre_o   = sr_d[DEPTH-1] & ~clr_i;

endmodule

// File: rtl/stream_addr_sequencer.sv
// Per-stage read/write address sequencer wrapped around a
// fixed-latency arithmetic core.
module stream_addr_sequencer
  import softmax_pkg::*;
#(
  parameter int TOTAL_VALUES = SM_TOTAL_VALUES,
  parameter int ADDR_WIDTH   = SM_ADDR_WIDTH,
  parameter int LATENCY      = EXPO_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  lat_cnt_done,
  output logic                  done,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(TOTAL_VALUES - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE =
    ADDR_WIDTH'(1);

  seq_state_e            state_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  lat_q;
  logic                  done_q;
  logic                  busy_q;
  logic                  wr_en_w;
  logic                  pre_w;

  // wr_en is the delay-line tap itself, so it stays a flop output
  valid_delay_line #(
    .DEPTH (LATENCY)
  ) u_dly (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (abort),
    .valid_i (rd_en_q),
    .valid_o (wr_en_w),
    .pre_o   (pre_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      lat_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else if (abort) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      lat_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      if (wr_en_w) wr_addr_q <= wr_addr_q + ONE;
      // set a cycle early so the level lines up with first wr_en
      if (pre_w) lat_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= ISSUE;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            lat_q     <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        ISSUE: begin
          if (rd_addr_q == LAST) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            rd_addr_q <= rd_addr_q + ONE;
          end
        end
        DRAIN: begin
          if (wr_en_w && wr_addr_q == LAST) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end
        end
        FINISH: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign wr_en        = wr_en_w;
  assign wr_addr      = wr_addr_q;
  assign lat_cnt_done = lat_q;
  assign done         = done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_stream_addr_sequencer.sv
// Directed bench: a nominal instance (5 values, latency 3)
// and a minimal one (1 value, latency 1).
module tb_stream_addr_sequencer;

  localparam int AW = 10;
  localparam int TA = 5;
  localparam int LA = 3;
  localparam int TB = 1;
  localparam int LB = 1;

  logic          clk;
  logic          rst;
  logic [1:0]    start;
  logic [1:0]    abort;
  logic [1:0]    rd_en;
  logic [1:0]    wr_en;
  logic [1:0]    lat;
  logic [1:0]    done;
  logic [1:0]    busy;
  logic [AW-1:0] rd_addr [2];
  logic [AW-1:0] wr_addr [2];

  int total;
  int bad;
  int cyc;
  int ps [2];
  int ab [2];
  int dones [2];
  int rdq [2][$];
  int wrq [2][$];

  stream_addr_sequencer #(
    .TOTAL_VALUES (TA),
    .ADDR_WIDTH   (AW),
    .LATENCY      (LA)
  ) dut_a (
    .clk          (clk),
    .rst          (rst),
    .start        (start[0]),
    .abort        (abort[0]),
    .rd_en        (rd_en[0]),
    .rd_addr      (rd_addr[0]),
    .wr_en        (wr_en[0]),
    .wr_addr      (wr_addr[0]),
    .lat_cnt_done (lat[0]),
    .done         (done[0]),
    .busy         (busy[0])
  );

  stream_addr_sequencer #(
    .TOTAL_VALUES (TB),
    .ADDR_WIDTH   (AW),
    .LATENCY      (LB)
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .start        (start[1]),
    .abort        (abort[1]),
    .rd_en        (rd_en[1]),
    .rd_addr      (rd_addr[1]),
    .wr_en        (wr_en[1]),
    .wr_addr      (wr_addr[1]),
    .lat_cnt_done (lat[1]),
    .done         (done[1]),
    .busy         (busy[1])
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  function automatic int tv(int i);
    return (i == 0) ? TA : TB;
  endfunction

  function automatic int lt(int i);
    return (i == 0) ? LA : LB;
  endfunction

  // expected {rd_en, wr_en, lat, done, busy} in cycle c
  function automatic logic [4:0] expv(int i, int c);
    int t;
    int l;
    int p;
    logic [4:0] v;
    t = tv(i);
    l = lt(i);
    p = ps[i];
    v = '0;
    if (p >= 0 && !(ab[i] > p && c > ab[i])) begin
      v[4] = (c >= p + 1) && (c <= p + t);
      v[3] = (c >= p + 1 + l) && (c <= p + t + l);
      v[2] = (c >= p + 1 + l);
      v[1] = (c == p + t + l + 1);
      v[0] = (c >= p + 1) && (c <= p + t + l + 1);
    end
    return v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s @cyc %0d: got %0d expected %0d",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic cyc_check();
    logic [4:0] e;
    string n;
    for (int i = 0; i < 2; i++) begin
      e = expv(i, cyc);
      n = (i == 0) ? "a" : "b";
      chk({n, ".rd_en"}, 32'(rd_en[i]), 32'(e[4]));
      chk({n, ".wr_en"}, 32'(wr_en[i]), 32'(e[3]));
      chk({n, ".lat"},   32'(lat[i]),   32'(e[2]));
      chk({n, ".done"},  32'(done[i]),  32'(e[1]));
      chk({n, ".busy"},  32'(busy[i]),  32'(e[0]));
      if (rd_en[i] === 1'b1) begin
        if (rdq[i].size() == 0)
          chk({n, ".rd_extra"}, 32'd1, 32'd0);
        else
          chk({n, ".rd_addr"}, 32'(rd_addr[i]),
              32'(rdq[i].pop_front()));
      end
      if (wr_en[i] === 1'b1) begin
        if (wrq[i].size() == 0)
          chk({n, ".wr_extra"}, 32'd1, 32'd0);
        else
          chk({n, ".wr_addr"}, 32'(wr_addr[i]),
              32'(wrq[i].pop_front()));
      end
      if (done[i] === 1'b1) dones[i]++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    cyc_check();
  endtask

  task automatic go(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic begin_pass(int i);
    start[i] = 1'b1;
    ps[i] = cyc;
    rdq[i].delete();
    wrq[i].delete();
    for (int k = 0; k < tv(i); k++) begin
      rdq[i].push_back(k);
      wrq[i].push_back(k);
    end
    step();
    start[i] = 1'b0;
  endtask

  task automatic pulse_start(int i);
    start[i] = 1'b1;
    step();
    start[i] = 1'b0;
  endtask

  task automatic do_abort(int i, logic with_start);
    abort[i] = 1'b1;
    start[i] = with_start;
    ab[i] = cyc;
    rdq[i].delete();
    wrq[i].delete();
    step();
    abort[i] = 1'b0;
    start[i] = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ps[i] = -1;
      ab[i] = -1;
      rdq[i].delete();
      wrq[i].delete();
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    dones[0] = 0;
    dones[1] = 0;
    model_reset();
    start = '0;
    abort = '0;
    rst = 1'b1;
    #12;
    cyc_check();
    chk("a.rd_addr_rst", 32'(rd_addr[0]), 32'd0);
    chk("a.wr_addr_rst", 32'(wr_addr[0]), 32'd0);
    #3;
    rst = 1'b0;
    go(3);

    // nominal pass with ignored starts at +2 and +6
    begin_pass(0);
    go(1);
    pulse_start(0);
    go(3);
    pulse_start(0);
    go(3);
    chk("a.dones_pass1", 32'(dones[0]), 32'd1);

    // back-to-back pass, aborted mid-drain
    begin_pass(0);
    go(5);
    do_abort(0, 1'b0);
    go(1);
    do_abort(0, 1'b1);
    go(1);

    // clean pass after abort
    begin_pass(0);
    go(12);
    chk("a.dones_pass3", 32'(dones[0]), 32'd2);
    chk("a.rdq_empty", 32'(rdq[0].size()), 32'd0);
    chk("a.wrq_empty", 32'(wrq[0].size()), 32'd0);

    // single value, single-cycle latency
    begin_pass(1);
    go(5);
    chk("b.dones", 32'(dones[1]), 32'd1);
    chk("b.rdq_empty", 32'(rdq[1].size()), 32'd0);
    chk("b.wrq_empty", 32'(wrq[1].size()), 32'd0);
    begin_pass(1);
    go(4);
    chk("b.dones2", 32'(dones[1]), 32'd2);

    // asynchronous reset in the middle of a pass
    begin_pass(0);
    go(4);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    cyc_check();
    chk("a.rd_addr_arst", 32'(rd_addr[0]), 32'd0);
    chk("a.wr_addr_arst", 32'(wr_addr[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    go(12);
    chk("a.dones_final", 32'(dones[0]), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_addr_sequencer.md
Name: stream_addr_sequencer

Overview:
- Per-stage read/write sequencer for the pipelined softmax datapath.
- Sits between control_unit and one arithmetic core (exponent, reciprocal or multiplier).
- On a start pulse it streams TOTAL_VALUES read addresses into the source RAM port and tracks the core's fixed pipeline latency with a valid delay line.
- It issues matching write enables/addresses to the destination RAM, and returns the latency-done level and the pass-done pulse that control_unit consumes.

Parameters:
- TOTAL_VALUES, 5, number of elements per softmax vector (>=1)
- ADDR_WIDTH, 10, RAM address width
- LATENCY, 8, core pipeline depth in clock cycles (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse from control_unit; begins a pass; ignored while busy
- abort  in  1  synchronous clear; returns to IDLE without a done pulse
- rd_en  out  1  source RAM port enable (ram1_enable_b style)
- rd_addr  out  ADDR_WIDTH  source RAM read address
- wr_en  out  1  destination RAM enable + write enable
- wr_addr  out  ADDR_WIDTH  destination RAM write address
- lat_cnt_done  out  1  level; high from the first wr_en until the next start
- done  out  1  one-cycle pulse when the pass completes
- busy  out  1  high in every non-IDLE state

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs are 0, both address counters are 0 and the delay line is cleared.
- All outputs are registered.

States:
- IDLE
  - start=1 -> ISSUE.
  - Clear rd_addr, wr_addr and lat_cnt_done.
- ISSUE
  - rd_en=1 every cycle.
  - rd_addr goes 0,1,...,TOTAL_VALUES-1, one per cycle.
  - Move to DRAIN in the cycle rd_addr=TOTAL_VALUES-1 is presented.
- DRAIN
  - rd_en=0 and rd_addr holds its last value.
  - Wait until TOTAL_VALUES writes have been issued -> FINISH.
- FINISH
  - done=1 for exactly one cycle, then IDLE.
  - busy=1 in this cycle.

Timing:
- First rd_en is asserted in the cycle after start is sampled.
- wr_en in cycle t+LATENCY mirrors rd_en in cycle t, via the LATENCY-deep delay line.
- wr_addr starts at 0 and increments after each wr_en.
- lat_cnt_done rises with the first wr_en and stays high until the next accepted start.
- done is asserted in the cycle after the last wr_en.
- busy is high for TOTAL_VALUES+LATENCY+1 cycles per pass.

Width rules:
- Counters are ADDR_WIDTH bits.
- TOTAL_VALUES must not exceed 2^ADDR_WIDTH.
- No wrap occurs within a pass.
- Counters reset to 0 at every accepted start.

Boundary conditions:
- start while busy: ignored, with no effect on counters or outputs.
- abort in any state: next cycle IDLE, delay line flushed, rd_en=wr_en=0, counters 0, lat_cnt_done=0, no done pulse.
- abort and start in the same cycle: abort wins and start is dropped.
- TOTAL_VALUES=1: ISSUE lasts one cycle and exactly one write is issued.
- LATENCY=1: wr_en trails rd_en by one cycle; reads and writes overlap.
- Async reset mid-pass: immediate return to the reset state, with no done pulse.

Decomposition:
- softmax_pkg holds:
  - ADDR_WIDTH and default TOTAL_VALUES
  - state encoding constants (IDLE, ISSUE, DRAIN, FINISH; 2-bit)
  - per-core latency constants EXPO_LATENCY, RECI_LATENCY, MULTI_LATENCY
- Sub-module valid_delay_line (parameter DEPTH):
  - 1-bit shift register with sync clear and async reset
  - reused for each stage instance

Test Plan:
- Reset: rst=1 for 15 ns, then release -> all outputs 0 and busy=0, with no activity until start.
- Nominal pass, TOTAL_VALUES=5, LATENCY=3, start pulsed at cycle 0:
  - rd_en high in cycles 1-5 with rd_addr 0..4
  - wr_en high in cycles 4-8 with wr_addr 0..4
  - lat_cnt_done rises at cycle 4
  - done high at cycle 9 only
  - busy high in cycles 1-9
- Busy start: extra start pulses at cycles 2 and 6 -> no change to the nominal trace; exactly one done.
- Abort mid-drain: abort at cycle 6 -> from cycle 7, wr_en=0, busy=0, lat_cnt_done=0; no done pulse. A new start at cycle 10 gives a full clean pass with addresses 0..4.
- Edge case, TOTAL_VALUES=1, LATENCY=1, start at cycle 0 -> rd_en at cycle 1 (addr 0), wr_en at cycle 2 (addr 0), done at cycle 3.
- Back-to-back passes: start again in the cycle after done -> lat_cnt_done clears, the second pass repeats the nominal trace offset by 10 cycles, and the counters restart at 0.
